alu_packet_parser: RTL and testbench
====================================

# alu_packet_parser

Receive-side framing stage for the UART ALU. It consumes the byte stream from the UART receiver's AXI-stream master port and decodes the 4-byte packet header: opcode, reserved, length LSB, length MSB. It then packs the payload into little-endian 32-bit words with byte-keep and last flags for the ALU/echo datapath. Malformed packets are dropped here, and an error pulse is reported, so the downstream datapath only ever sees well-formed packets.

## Interface

Parameters:
- DATA_WIDTH_P, 8: byte width of the input stream. Fixed at 8; any other value is unsupported.
- MAX_LEN_P, 16'd1024: largest legal total packet length in bytes, header included.

Ports:
- clk  in  1  single clock, driven by the PLL output; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_axis_tdata  in  8  received byte from the UART receiver.
- s_axis_tvalid  in  1  received byte is valid.
- s_axis_tready  out  1  parser accepts the byte on this cycle.
- m_word_o  out  32  payload word. The first payload byte of the word is in [7:0].
- m_keep_o  out  4  per-byte valid mask for m_word_o. Bit i qualifies bits [8i+7:8i].
- m_last_o  out  1  the current word is the final word of the packet.
- m_valid_o  out  1  word outputs are valid.
- m_ready_i  in  1  downstream consumes the word.
- opcode_o  out  8  opcode of the current packet. Held stable from the hdr_valid_o pulse until the next header completes.
- hdr_valid_o  out  1  one-cycle pulse: a legal header has been accepted.
- opcode_err_o  out  1  one-cycle pulse: unknown opcode; the packet is being dropped.
- len_err_o  out  1  one-cycle pulse: illegal length; any remaining payload is being dropped.
- busy_o  out  1  high in every state except S_OPCODE.

## Operation

Byte transfer and packet format:
- A byte is transferred when s_axis_tvalid && s_axis_tready.
- Legal opcodes: 0xEC (echo), 0xA8 (add32), 0xAD (mul32), 0xAE (div32).
- The length field is 16 bits: {MSB, LSB}. It is the total packet length, header included.

State machine:
- S_OPCODE: accept a byte, latch it as the opcode, go to S_RSVD.
- S_RSVD: accept a byte, discard it, go to S_LEN_LO.
- S_LEN_LO: accept a byte, latch it as the length LSB, go to S_LEN_HI.
- S_LEN_HI: accept a byte, form the length L, then check it in this order:
  - Opcode illegal: pulse opcode_err_o. Set remaining = L−4 (saturate at 0). Go to S_DROP, or to S_OPCODE if remaining = 0.
  - L < 4, or L > MAX_LEN_P: pulse len_err_o. Set remaining = L−4 if L ≥ 4, else 0. Go to S_DROP, or to S_OPCODE if remaining = 0.
  - ALU opcode with L < 12 or (L−4) mod 4 ≠ 0: pulse len_err_o. Go to S_DROP with remaining = L−4, or to S_OPCODE if remaining = 0.
  - Otherwise: pulse hdr_valid_o and update opcode_o. Set remaining = L−4. Go to S_PAYLOAD, or to S_OPCODE if remaining = 0 (only possible for echo with L = 4; no words are emitted).
- S_PAYLOAD:
  - Accept a byte into lane k of the word buffer, set keep[k], increment k, decrement remaining.
  - When k reaches 4 or remaining reaches 0, go to S_EMIT.
- S_EMIT:
  - s_axis_tready = 0. m_valid_o = 1.
  - m_last_o = 1 when remaining = 0.
  - On m_ready_i, clear the buffer, keep and k. Go to S_PAYLOAD if remaining > 0, else S_OPCODE.
- S_DROP: accept and discard bytes, decrementing remaining. Go to S_OPCODE when it reaches 0.

Other rules:
- s_axis_tready = 1 in every state except S_EMIT.
- Unused word lanes are driven as 0. keep is always contiguous from bit 0.
- Reset values: state S_OPCODE, s_axis_tready 1, m_valid_o 0, m_last_o 0, m_word_o 0, m_keep_o 0, opcode_o 0, all pulses 0, busy_o 0.

## Timing

- A header of 4 accepted bytes produces hdr_valid_o, opcode_err_o or len_err_o on the cycle after the 4th byte is accepted. These pulses are registered.
- m_valid_o asserts on the cycle after the byte that fills the word, or after the packet's last byte.
- m_valid_o and the word outputs stay stable until m_ready_i is sampled high.
- Maximum input throughput is 4 bytes per 5 cycles, which is far above the UART byte rate.
- When m_ready_i is held low, the parser backpressures the UART receiver; the receiver's overrun handling is not this block's concern.
- rst_n low mid-packet: on the next edge, return to the reset values. A partial word is discarded and never emitted.
- The block has no timeout. A stalled packet waits indefinitely.

## Test plan

- Add packet EC-free: A8 00 0C 00 01 00 00 00 02 00 00 00 → hdr_valid_o with opcode_o = 0xA8. Word 0x00000001 with keep F, last 0. Then word 0x00000002 with keep F, last 1.
- Echo packet EC 00 07 00 41 42 43 → one word 0x00434241, keep 0111, last 1. State returns to S_OPCODE and busy_o falls.
- Unknown opcode 55 00 06 00 AA BB → opcode_err_o pulse, 2 bytes dropped, no m_valid_o. The next valid packet parses normally.
- Illegal length: A8 00 0A 00 plus 6 bytes → len_err_o pulse, 6 bytes dropped, no output. A header EC 00 02 00 → len_err_o, then straight back to S_OPCODE.
- Backpressure: hold m_ready_i low for 20 cycles during the add packet → s_axis_tready stays 0 and m_word_o stays stable. No bytes are lost once m_ready_i is released.
- Reset mid-payload: deassert rst_n after 6 bytes of the add packet → all outputs take their reset values. A subsequent full echo packet decodes correctly.

Source files
------------

// File: rtl/alu_packet_parser.sv
// Receive framing for the UART ALU: decodes the 4-byte header and packs payload into LE 32-bit words.
// Latency: header verdict pulse 1 cycle after the 4th header byte; a word is valid 1 cycle after its last byte.
// Backpressure: s_axis_tready drops while a word waits for m_ready_i; malformed packets are drained, not emitted.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready  byte stream from the UART receiver
//   m_word_o/keep_o/last_o      payload word, byte mask, end-of-packet flag
//   m_valid_o/m_ready_i         word handshake
//   opcode_o                    opcode of the last accepted header
//   hdr_valid_o                 pulse: legal header accepted
//   opcode_err_o/len_err_o      pulses: packet rejected and being dropped
//   busy_o                      parser is inside a packet
module alu_packet_parser #(
    parameter int unsigned DATA_WIDTH_P = 8,
    parameter logic [15:0] MAX_LEN_P    = 16'd1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [31:0]             m_word_o,
    output logic [3:0]              m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [7:0]              opcode_o,
    output logic                    hdr_valid_o,
    output logic                    opcode_err_o,
    output logic                    len_err_o,
    output logic                    busy_o
);

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA8;
    localparam logic [7:0] OP_MUL  = 8'hAD;
    localparam logic [7:0] OP_DIV  = 8'hAE;

    typedef enum logic [2:0] {
        S_OPCODE,
        S_RSVD,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_EMIT,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_raw_q, op_raw_d;     // opcode byte of the packet in flight
    logic [7:0]  opcode_q, opcode_d;     // opcode published on hdr_valid
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] rem_q, rem_d;           // payload bytes still to accept
    logic [31:0] word_q, word_d;
    logic [3:0]  keep_q, keep_d;
    logic [1:0]  k_q, k_d;               // next free lane
    logic        hdr_q, hdr_d;
    logic        op_err_q, op_err_d;
    logic        len_err_q, len_err_d;

    logic [7:0]  byte_in;
    logic        xfer;
    logic [15:0] len;
    logic [15:0] rem_hdr;
    logic        op_legal;
    logic        hdr_ok;

    assign byte_in = s_axis_tdata[7:0];

    always_comb begin
        state_d   = state_q;
        op_raw_d  = op_raw_q;
        opcode_d  = opcode_q;
        len_lo_d  = len_lo_q;
        rem_d     = rem_q;
        word_d    = word_q;
        keep_d    = keep_q;
        k_d       = k_q;
        hdr_d     = 1'b0;
        op_err_d  = 1'b0;
        len_err_d = 1'b0;
        hdr_ok    = 1'b0;

        s_axis_tready = (state_q != S_EMIT);
        xfer          = s_axis_tvalid && s_axis_tready;
        len           = {byte_in, len_lo_q};
        // Length counts the header, so payload is L-4, clamped for runt lengths.
        rem_hdr       = (len >= 16'd4) ? (len - 16'd4) : 16'd0;
        op_legal      = (op_raw_q == OP_ECHO) || (op_raw_q == OP_ADD) ||
                        (op_raw_q == OP_MUL)  || (op_raw_q == OP_DIV);

        case (state_q)
            S_OPCODE: begin
                if (xfer) begin
                    op_raw_d = byte_in;
                    state_d  = S_RSVD;
                end
            end
            S_RSVD: begin
                if (xfer) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_lo_d = byte_in;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    rem_d = rem_hdr;
                    // Checks are prioritised: opcode first, then generic length, then ALU operand shape.
                    if (!op_legal) begin
                        op_err_d = 1'b1;
                    end else if ((len < 16'd4) || (len > MAX_LEN_P)) begin
                        len_err_d = 1'b1;
                    end else if ((op_raw_q != OP_ECHO) &&
                                 ((len < 16'd12) || (len[1:0] != 2'b00))) begin
                        len_err_d = 1'b1;
                    end else begin
                        hdr_ok   = 1'b1;
                        hdr_d    = 1'b1;
                        opcode_d = op_raw_q;
                    end
                    if (rem_hdr == 16'd0) begin
                        state_d = S_OPCODE;
                    end else if (hdr_ok) begin
                        state_d = S_PAYLOAD;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    word_d[{k_q, 3'b000} +: 8] = byte_in;
                    keep_d[k_q]                = 1'b1;
                    k_d                        = k_q + 2'd1;
                    rem_d                      = rem_q - 16'd1;
                    if ((k_q == 2'd3) || (rem_q == 16'd1)) begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (m_ready_i) begin
                    word_d  = 32'd0;
                    keep_d  = 4'd0;
                    k_d     = 2'd0;
                    state_d = (rem_q != 16'd0) ? S_PAYLOAD : S_OPCODE;
                end
            end
            S_DROP: begin
                if (xfer) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = S_OPCODE;
                    end
                end
            end
            default: begin
                state_d = S_OPCODE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_OPCODE;
            op_raw_q  <= 8'd0;
            opcode_q  <= 8'd0;
            len_lo_q  <= 8'd0;
            rem_q     <= 16'd0;
            word_q    <= 32'd0;
            keep_q    <= 4'd0;
            k_q       <= 2'd0;
            hdr_q     <= 1'b0;
            op_err_q  <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_raw_q  <= op_raw_d;
            opcode_q  <= opcode_d;
            len_lo_q  <= len_lo_d;
            rem_q     <= rem_d;
            word_q    <= word_d;
            keep_q    <= keep_d;
            k_q       <= k_d;
            hdr_q     <= hdr_d;
            op_err_q  <= op_err_d;
            len_err_q <= len_err_d;
        end
    end

    assign m_word_o     = word_q;
    assign m_keep_o     = keep_q;
    assign m_valid_o    = (state_q == S_EMIT);
    assign m_last_o     = (state_q == S_EMIT) && (rem_q == 16'd0);
    assign opcode_o     = opcode_q;
    assign hdr_valid_o  = hdr_q;
    assign opcode_err_o = op_err_q;
    assign len_err_o    = len_err_q;
    assign busy_o       = (state_q != S_OPCODE);

endmodule

// File: tb/tb_alu_packet_parser.sv
// Bench for alu_packet_parser: directed packets plus random packets against a packet-level model.
// Latency: n/a (testbench).
// Backpressure: m_ready_i is randomised, and forced low for a hold window.
module tb_alu_packet_parser;

    localparam logic [15:0] MAX_LEN = 16'd64;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] w;
        logic [3:0]  k;
        logic        l;
    } exp_w_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_word_o;
    logic [3:0]  m_keep_o;
    logic        m_last_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic [7:0]  opcode_o;
    logic        hdr_valid_o;
    logic        opcode_err_o;
    logic        len_err_o;
    logic        busy_o;

    alu_packet_parser #(.DATA_WIDTH_P(8), .MAX_LEN_P(MAX_LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_word_o     (m_word_o),
        .m_keep_o     (m_keep_o),
        .m_last_o     (m_last_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .opcode_o     (opcode_o),
        .hdr_valid_o  (hdr_valid_o),
        .opcode_err_o (opcode_err_o),
        .len_err_o    (len_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_w_t     wq[$];     // expected words in order
    int         ev_q[$];   // expected header verdicts: 1 hdr, 2 opcode err, 3 len err
    logic [7:0] eo_q[$];   // opcode belonging to each verdict
    bit         hold = 1'b0;
    bit         prev_vld = 1'b0;
    logic [31:0] prev_word = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_op(input logic [7:0] op);
        return (op == 8'hEC) || (op == 8'hA8) || (op == 8'hAD) || (op == 8'hAE);
    endfunction

    // Packet-level reference: classify the header, then slice payload into 4-byte words.
    task automatic model_packet(input bq_t p);
        logic [7:0]  op;
        int          len;
        int          n;
        exp_w_t      e;
        op  = p[0];
        len = int'({p[3], p[2]});
        eo_q.push_back(op);
        if (!legal_op(op)) begin
            ev_q.push_back(2);
        end else if (len < 4 || len > int'(MAX_LEN)) begin
            ev_q.push_back(3);
        end else if (op != 8'hEC && (len < 12 || (len % 4) != 0)) begin
            ev_q.push_back(3);
        end else begin
            ev_q.push_back(1);
            for (int i = 4; i < len; i += 4) begin
                n   = (len - i < 4) ? (len - i) : 4;
                e.w = 32'd0;
                for (int j = 0; j < n; j++) e.w = e.w | (32'(p[i + j]) << (8 * j));
                e.k = 4'((1 << n) - 1);
                e.l = (i + 4 >= len);
                wq.push_back(e);
            end
        end
    endtask

    task automatic make_pkt(input logic [7:0] op, input int len, output bq_t p);
        p = {};
        p.push_back(op);
        p.push_back(8'($urandom_range(0, 255)));
        p.push_back(8'(len & 255));
        p.push_back(8'((len >> 8) & 255));
        for (int i = 4; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        g = 0;
        while (!s_axis_tready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk("tready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    // Sends n bytes of p (all when n < 0); header verdict must follow the 4th byte by one cycle.
    task automatic send_bytes(input bq_t p, input int n);
        int lim;
        lim = (n < 0) ? p.size() : n;
        for (int i = 0; i < lim; i++) begin
            send_byte(p[i]);
            if (i == 3) begin
                @(negedge clk);
                chk("verdict_timing", {31'd0, hdr_valid_o | opcode_err_o | len_err_o}, 32'd1);
            end
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((wq.size() != 0 || ev_q.size() != 0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        chk("busy_idle", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic run_packet(input bq_t p);
        model_packet(p);
        send_bytes(p, -1);
        drain();
    endtask

    task automatic check_reset_vals();
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd1);
        chk("rst_valid",  {31'd0, m_valid_o}, 32'd0);
        chk("rst_last",   {31'd0, m_last_o}, 32'd0);
        chk("rst_word",   m_word_o, 32'd0);
        chk("rst_keep",   {28'd0, m_keep_o}, 32'd0);
        chk("rst_opcode", {24'd0, opcode_o}, 32'd0);
        chk("rst_pulses", {29'd0, hdr_valid_o, opcode_err_o, len_err_o}, 32'd0);
        chk("rst_busy",   {31'd0, busy_o}, 32'd0);
    endtask

    // Output monitor: choose m_ready for the coming edge, then score what that edge will transfer.
    always @(negedge clk) begin
        exp_w_t     e;
        int         code;
        logic [7:0] eop;
        m_ready_i = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (rst_n) begin
            if (m_valid_o) begin
                chk("tready_in_emit", {31'd0, s_axis_tready}, 32'd0);
                if (hold && prev_vld) chk("hold_stable", m_word_o, prev_word);
                if (m_ready_i) begin
                    if (wq.size() == 0) begin
                        chk("word_unexpected", {31'd0, m_valid_o}, 32'd0);
                    end else begin
                        e = wq.pop_front();
                        chk("word", m_word_o, e.w);
                        chk("keep", {28'd0, m_keep_o}, {28'd0, e.k});
                        chk("last", {31'd0, m_last_o}, {31'd0, e.l});
                    end
                end
            end
            prev_vld  = m_valid_o && !m_ready_i;
            prev_word = m_word_o;
            if (hdr_valid_o || opcode_err_o || len_err_o) begin
                chk("pulse_onehot", 32'(hdr_valid_o) + 32'(opcode_err_o) + 32'(len_err_o), 32'd1);
                code = hdr_valid_o ? 1 : (opcode_err_o ? 2 : 3);
                if (ev_q.size() == 0) begin
                    chk("pulse_unexpected", 32'(code), 32'd0);
                end else begin
                    eop = eo_q.pop_front();
                    chk("pulse_kind", 32'(code), 32'(ev_q.pop_front()));
                    if (code == 1) chk("opcode", {24'd0, opcode_o}, {24'd0, eop});
                end
            end
        end else begin
            prev_vld = 1'b0;
        end
    end

    initial begin
        bq_t        p;
        int         g;
        int         kind;
        int         len;
        logic [7:0] op;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        // Directed packets from the block's reference traffic.
        p = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        run_packet(p);
        p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        run_packet(p);
        p = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        run_packet(p);
        make_pkt(8'hA8, 10, p);
        run_packet(p);
        p = '{8'hEC, 8'h00, 8'h02, 8'h00};
        run_packet(p);
        make_pkt(8'hEC, 4, p);
        run_packet(p);
        make_pkt(8'hAD, int'(MAX_LEN), p);
        run_packet(p);
        make_pkt(8'hAE, int'(MAX_LEN) + 4, p);
        run_packet(p);

        // Backpressure: stall the first word for 20 cycles.
        make_pkt(8'hA8, 12, p);
        model_packet(p);
        hold = 1'b1;
        fork
            send_bytes(p, -1);
            begin
                g = 0;
                while (!m_valid_o && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                chk("hold_reached", {31'd0, m_valid_o}, 32'd1);
                repeat (20) @(negedge clk);
                hold = 1'b0;
            end
        join
        drain();

        // Reset in the middle of a payload word: nothing of it may appear.
        make_pkt(8'hA8, 12, p);
        model_packet(p);
        send_bytes(p, 6);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals();
        wq.delete();
        rst_n = 1'b1;
        p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        run_packet(p);

        // Random traffic.
        for (int n = 0; n < 50; n++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    op  = 8'hEC;
                    len = $urandom_range(4, 40);
                end
                1: begin
                    g   = $urandom_range(0, 2);
                    op  = (g == 0) ? 8'hA8 : ((g == 1) ? 8'hAD : 8'hAE);
                    len = 4 * $urandom_range(3, 16);
                end
                2: begin
                    op = 8'($urandom_range(0, 255));
                    while (legal_op(op)) op = 8'($urandom_range(0, 255));
                    len = $urandom_range(0, 20);
                end
                default: begin
                    g   = $urandom_range(0, 3);
                    op  = (g == 0) ? 8'hEC : ((g == 1) ? 8'hA8 : ((g == 2) ? 8'hAD : 8'hAE));
                    len = $urandom_range(0, 80);
                end
            endcase
            make_pkt(op, len, p);
            run_packet(p);
        end

        chk("words_left", 32'(wq.size()), 32'd0);
        chk("events_left", 32'(ev_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
